// File: rtl/vga_pkg.sv
// +---------------------------------------------------------------------------+
// | vga_pkg : 640x480@60 timing defaults, counter width, axis timing helper    |
// | Rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
`default_nettype none

package vga_pkg;

  localparam int CNT_W = 10;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    cnt_t total;
    cnt_t sync_start;
    cnt_t sync_end;
  } axis_timing_t;

  function automatic axis_timing_t axis_timing(input int active, input int fp,
                                               input int sync, input int bp);
    axis_timing_t t;
    t.total      = cnt_t'(active + fp + sync + bp);
    t.sync_start = cnt_t'(active + fp);
    t.sync_end   = cnt_t'(active + fp + sync);
    return t;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_axis_counter.sv
// +---------------------------------------------------------------------------+
// | vga_axis_counter : one timing axis (count, wrap, active window, sync)      |
// | Rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
`default_nettype none

module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  output cnt_t count,
  output logic wrap,
  output logic active,
  output logic sync
);

  localparam axis_timing_t TIM  = axis_timing(ACTIVE, FP, SYNC, BP);
  localparam cnt_t         LAST = cnt_t'(TIM.total - cnt_t'(1));
  localparam cnt_t         ACT  = cnt_t'(ACTIVE);

  generate
    if ((ACTIVE + FP + SYNC + BP) > ((1 << CNT_W) - 1)) begin : g_range_err
      $error("vga_axis_counter: axis total exceeds counter range");
    end
  endgenerate

  cnt_t r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (inc) begin
      r_count <= wrap ? '0 : r_count + cnt_t'(1);
    end
  end

  assign count  = r_count;
  assign wrap   = inc && (r_count == LAST);
  assign active = (r_count < ACT);
  assign sync   = (r_count >= TIM.sync_start) && (r_count < TIM.sync_end);

endmodule

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// +---------------------------------------------------------------------------+
// | vga_timing_gen : registered VGA sync/DE/coordinate decode; optional colour |
// | bars when VGA_TEST_PATTERN_EN is defined.  Rev 1.0                         |
// +---------------------------------------------------------------------------+
`default_nettype none

module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0
) (
  input  logic             clk_25mhz,
  input  logic             rst,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             frame_start,
  output logic             line_start
`ifdef VGA_TEST_PATTERN_EN
  ,
  output logic [2:0]       rgb
`endif
);

  cnt_t w_h_cnt, w_v_cnt;
  logic w_h_wrap, w_v_wrap, w_h_act, w_v_act, w_h_sync, w_v_sync;
  logic w_de;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
  ) u_h_axis (
    .clk(clk_25mhz), .rst(rst), .inc(1'b1),
    .count(w_h_cnt), .wrap(w_h_wrap), .active(w_h_act), .sync(w_h_sync)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
  ) u_v_axis (
    .clk(clk_25mhz), .rst(rst), .inc(w_h_wrap),
    .count(w_v_cnt), .wrap(w_v_wrap), .active(w_v_act), .sync(w_v_sync)
  );

  // Frame wrap is implied by (0,0); the vertical wrap flag has no consumer.
  logic w_unused_vwrap;
  assign w_unused_vwrap = w_v_wrap;

  assign w_de = w_h_act && w_v_act;

  always_ff @(posedge clk_25mhz) begin
    if (rst) begin
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      de          <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else begin
      hsync       <= w_h_sync ? HSYNC_POL : ~HSYNC_POL;
      vsync       <= w_v_sync ? VSYNC_POL : ~VSYNC_POL;
      de          <= w_de;
      pixel_x     <= w_de ? w_h_cnt : '0;
      pixel_y     <= w_de ? w_v_cnt : '0;
      frame_start <= (w_h_cnt == '0) && (w_v_cnt == '0);
      line_start  <= (w_h_cnt == '0);
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam cnt_t BAR_W = cnt_t'(H_ACTIVE / 8);

  cnt_t w_bar;
  logic w_unused_bar;
  assign w_bar        = w_h_cnt / BAR_W;
  assign w_unused_bar = |w_bar[CNT_W-1:3];

  // Bar 0 is white, bar 7 black.
  always_ff @(posedge clk_25mhz) begin
    if (rst) begin
      rgb <= 3'b000;
    end else begin
      rgb <= w_de ? ~w_bar[2:0] : 3'b000;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a default-timing DUT for line-level checks and a reduced
// timing DUT (96x21) so whole frames fit in a short run.
`default_nettype none

module tb_vga_timing_gen;

  // reduced timing for the small instance
  localparam int SH_A = 64, SH_F = 8, SH_S = 12, SH_B = 12;
  localparam int SV_A = 12, SV_F = 3, SV_S = 2,  SV_B = 4;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic [9:0] px;
    logic [9:0] py;
    logic       fs;
    logic       ls;
    logic [2:0] rgb;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       hs_d, vs_d, de_d, fs_d, ls_d;
  logic [9:0] px_d, py_d;
  logic       hs_s, vs_s, de_s, fs_s, ls_s;
  logic [9:0] px_s, py_s;
  logic [2:0] rgb_d, rgb_s;

  vga_timing_gen u_dut_def (
    .clk_25mhz(clk), .rst(rst), .hsync(hs_d), .vsync(vs_d), .de(de_d),
    .pixel_x(px_d), .pixel_y(py_d), .frame_start(fs_d), .line_start(ls_d)
`ifdef VGA_TEST_PATTERN_EN
    , .rgb(rgb_d)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(SH_A), .H_FP(SH_F), .H_SYNC(SH_S), .H_BP(SH_B),
    .V_ACTIVE(SV_A), .V_FP(SV_F), .V_SYNC(SV_S), .V_BP(SV_B),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) u_dut_small (
    .clk_25mhz(clk), .rst(rst), .hsync(hs_s), .vsync(vs_s), .de(de_s),
    .pixel_x(px_s), .pixel_y(py_s), .frame_start(fs_s), .line_start(ls_s)
`ifdef VGA_TEST_PATTERN_EN
    , .rgb(rgb_s)
`endif
  );

`ifndef VGA_TEST_PATTERN_EN
  assign rgb_d = 3'b000;
  assign rgb_s = 3'b000;
`endif

  int total = 0;
  int bad   = 0;

  exp_t q_def[$];
  exp_t q_small[$];

  task automatic chk_out(input string name, input exp_t a, input exp_t e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got hs=%b vs=%b de=%b x=%0d y=%0d fs=%b ls=%b rgb=%b, want hs=%b vs=%b de=%b x=%0d y=%0d fs=%b ls=%b rgb=%b",
               name, a.hs, a.vs, a.de, a.px, a.py, a.fs, a.ls, a.rgb,
               e.hs, e.vs, e.de, e.px, e.py, e.fs, e.ls, e.rgb);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Expected registered outputs for counter state (h,v) sampled with reset r.
  function automatic exp_t model_out(input bit r, input int h, input int v,
                                     input int ha, input int hf, input int hs,
                                     input int va, input int vf, input int vs);
    exp_t e;
    int   bar;
    if (r) begin
      e = '{hs: 1'b1, vs: 1'b1, de: 1'b0, px: 10'd0, py: 10'd0,
            fs: 1'b0, ls: 1'b0, rgb: 3'b000};
    end else begin
      e.de  = (h < ha) && (v < va);
      e.hs  = !((h >= ha + hf) && (h < ha + hf + hs));
      e.vs  = !((v >= va + vf) && (v < va + vf + vs));
      e.px  = e.de ? 10'(h) : 10'd0;
      e.py  = e.de ? 10'(v) : 10'd0;
      e.fs  = (h == 0) && (v == 0);
      e.ls  = (h == 0);
      bar   = h / (ha / 8);
      e.rgb = 3'b000;
`ifdef VGA_TEST_PATTERN_EN
      if (e.de) e.rgb = ~3'(bar);
`endif
    end
    return e;
  endfunction

  int mh_d = 0, mv_d = 0, mh_s = 0, mv_s = 0;

  task automatic step(input bit r);
    rst = r;
    q_def.push_back(model_out(r, mh_d, mv_d, 640, 16, 96, 480, 10, 2));
    q_small.push_back(model_out(r, mh_s, mv_s, SH_A, SH_F, SH_S, SV_A, SV_F, SV_S));
    if (r) begin
      mh_d = 0; mv_d = 0; mh_s = 0; mv_s = 0;
    end else begin
      if (mh_d == 799) begin mh_d = 0; mv_d = (mv_d == 524) ? 0 : mv_d + 1; end
      else mh_d++;
      if (mh_s == SH_A + SH_F + SH_S + SH_B - 1) begin
        mh_s = 0;
        mv_s = (mv_s == SV_A + SV_F + SV_S + SV_B - 1) ? 0 : mv_s + 1;
      end else mh_s++;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: per-cycle scoreboard compare plus line/frame aggregates.
  exp_t act, expv;
  bit   last_rst = 1'b1;
  bit   lv_d = 1'b0, fv_s = 1'b0;
  int   lgap = 0, lde = 0, lhs = 0;
  int   fgap = 0, fde = 0, fvs = 0;

  always @(negedge clk) begin
    if (q_def.size() > 0) begin
      expv = q_def.pop_front();
      act  = {hs_d, vs_d, de_d, px_d, py_d, fs_d, ls_d, rgb_d};
      chk_out("def_cycle", act, expv);
    end
    if (q_small.size() > 0) begin
      expv = q_small.pop_front();
      act  = {hs_s, vs_s, de_s, px_s, py_s, fs_s, ls_s, rgb_s};
      chk_out("small_cycle", act, expv);
    end
    if (last_rst) begin
      lv_d = 1'b0;
      fv_s = 1'b0;
    end else begin
      if (ls_d) begin
        if (lv_d) begin
          chk_int("line_period", lgap, 800);
          chk_int("line_de_count", lde, 640);
          chk_int("line_hsync_low", lhs, 96);
        end
        lgap = 0; lde = 0; lhs = 0; lv_d = 1'b1;
      end
      lgap++;
      lde += int'(de_d);
      lhs += int'(!hs_d);
      if (fs_s) begin
        if (fv_s) begin
          chk_int("frame_period", fgap, 2016);
          chk_int("frame_de_count", fde, 768);
          chk_int("frame_vsync_low", fvs, 192);
        end
        fgap = 0; fde = 0; fvs = 0; fv_s = 1'b1;
      end
      fgap++;
      fde += int'(de_s);
      fvs += int'(!vs_s);
    end
    last_rst = rst;
  end

  initial begin
    int n;
    repeat (5) step(1'b1);
    repeat (4232) step(1'b0);
    // mid-frame reset at line 7, pixel 30 of the small instance
    n = 0;
    while (!(mh_s == 30 && mv_s == 7) && n < 2100) begin
      step(1'b0);
      n++;
    end
    chk_int("reach_midframe_point", n < 2100 ? 1 : 0, 1);
    step(1'b1);
    repeat (2150) step(1'b0);
    repeat (3) @(posedge clk);
    chk_int("scoreboard_drained", q_def.size() + q_small.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Downstream consumer of the VGA pixel clock produced by the clock divider; runs entirely in the pixel-clock domain.
- Generates horizontal/vertical counters, HSYNC/VSYNC, the display-enable window, pixel coordinates and a frame-start strobe for 640x480@60 timing.
- Feeds the pixel/colour logic and the VGA output pins on the Fipsy XO2-1200.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HSYNC_POL, 0, active level of hsync (0 = active-low)
- VSYNC_POL, 0, active level of vsync (0 = active-low)

Ports:
- clk_25mhz  input  1  pixel clock from the clock divider; sole clock
- rst  input  1  synchronous, active-high reset
- hsync  output  1  horizontal sync, polarity per HSYNC_POL
- vsync  output  1  vertical sync, polarity per VSYNC_POL
- de  output  1  display enable; high inside the active window
- pixel_x  output  10  current column, valid when de=1
- pixel_y  output  10  current line, valid when de=1
- frame_start  output  1  one-cycle pulse at pixel (0,0)
- line_start  output  1  one-cycle pulse at h=0 of every line

Behaviour:
- Interface: one clock, clk_25mhz; reset rst is synchronous and active-high.
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Internal counters:
  - h_cnt and v_cnt, 10 bits each.
  - h_cnt increments every cycle and wraps at H_TOTAL-1 -> 0.
  - v_cnt increments only when h_cnt wraps, and wraps at V_TOTAL-1 -> 0 (simultaneous h/v wrap -> both 0).
- Reset:
  - While rst=1, the counters are held at 0.
  - All outputs are held at: hsync=~HSYNC_POL, vsync=~VSYNC_POL, de=0, pixel_x=0, pixel_y=0, frame_start=0, line_start=0.
  - rst asserted mid-frame takes effect at the next edge; there is no partial-frame completion.
- Output decode:
  - All outputs are registered, with 1-cycle latency from counters to outputs. Outputs in cycle n describe the counter values of cycle n-1.
  - All outputs are mutually aligned, with zero relative skew.
- Window rules:
  - de = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - hsync is active for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vsync is active for V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491), spanning whole lines.
  - pixel_x = h_cnt and pixel_y = v_cnt when de=1; both are forced to 0 when de=0.
  - line_start = (h_cnt==0); frame_start = (h_cnt==0 && v_cnt==0).
- First cycle after rst deasserts: outputs reflect (0,0), i.e. de=1, frame_start=1, line_start=1.
- Period checks: frame = 420000 cycles; line = 800 cycles.
- Comparisons are unsigned; parameter sums must fit in 10 bits (H_TOTAL, V_TOTAL <= 1023). This is checked by an elaboration-time assertion.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- Defined:
  - Adds output port rgb [2:0] (R,G,B, 1 bit each), registered and aligned with de.
  - Pattern: 8 vertical colour bars of H_ACTIVE/8 pixels. Bar index = pixel_x / 80; rgb = ~bar_index[2:0] (bar 0 = white, bar 7 = black).
  - rgb = 0 whenever de=0 or rst=1.
- Undefined: port rgb and all pattern logic are absent; the remaining behaviour is identical.

Decomposition:
- Shared package vga_pkg:
  - default timing constants for 640x480@60;
  - a function computing totals and sync start/end;
  - the counter width constant (10).
- Sub-module vga_axis_counter, instantiated twice (horizontal and vertical):
  - parameterised by ACTIVE/FP/SYNC/BP;
  - inputs: inc enable;
  - outputs: count, wrap, active, sync.
- Top level: registers the output decode and holds the optional pattern logic.

Test Plan:
- Reset: hold rst high for 5 cycles, then release -> outputs are at reset values during reset; the first cycle after release shows de=1, frame_start=1, pixel_x=0, pixel_y=0.
- Horizontal timing: run 2 lines -> de high for exactly 640 cycles per line; hsync low over h=656..751 (96 cycles); line_start period = 800 cycles.
- Vertical timing: run one full frame -> vsync low for exactly 1600 cycles covering lines 490..491; de never high on lines 480..524.
- Wrap: observe the transition at h=799, v=524 -> the next output shows h=0, v=0 with frame_start=1; frame_start period = 420000 cycles.
- Mid-frame reset: assert rst at line 200, pixel 300 for 1 cycle -> the next output cycle is at reset values; timing restarts from (0,0) exactly 1 cycle after release.
- With VGA_TEST_PATTERN_EN defined:
  - rgb = 3'b111 at pixel_x = 0..79 and 3'b000 at pixel_x = 560..639;
  - rgb = 0 during blanking.
